// File: rtl/rgmii_tx_speed_gen.sv
// RGMII transmit timing generator: builds ODDR d1/d2 values for TXC, TD and TX_CTL at 1G/100M/10M,
// splitting MAC bytes into nibbles at 10/100 and switching speed only on byte boundaries.
module rgmii_tx_speed_gen #(
    parameter int DIV_100M   = 5,
    parameter int DIV_10M    = 50,
    parameter bit BYTE_SPLIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed_i,
    input  logic [7:0] gmii_txd_i,
    input  logic       gmii_tx_en_i,
    input  logic       gmii_tx_er_i,
    output logic       gmii_tx_clk_en_o,
    output logic       txc_d1_o,
    output logic       txc_d2_o,
    output logic [3:0] txd_d1_o,
    output logic [3:0] txd_d2_o,
    output logic       tx_ctl_d1_o,
    output logic       tx_ctl_d2_o,
    output logic [1:0] active_speed_o,
    output logic       speed_change_o
);

    localparam int CW     = (DIV_10M > 2) ? $clog2(DIV_10M) : 1;
    localparam int P100_I = DIV_100M;
    localparam int P10_I  = DIV_10M;
    localparam logic [CW:0] P100 = P100_I[CW:0];
    localparam logic [CW:0] P10  = P10_I[CW:0];

    typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_e;

    function automatic logic [CW:0] period_of(input logic [1:0] spd);
        case (spd)
            2'b01:   period_of = P100;
            2'b00:   period_of = P10;
            default: period_of = (CW+1)'(1);
        endcase
    endfunction

    logic [1:0]    active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;
    logic [3:0]    hi_q, hi_d;
    logic          en_q, en_d, er_q, er_d;
    logic          clk_en_q, clk_en_d, chg_q, chg_d;
    logic          txc1_q, txc1_d, txc2_q, txc2_d;
    logic [3:0]    txd1_q, txd1_d, txd2_q, txd2_d;
    logic          ctl1_q, ctl1_d, ctl2_q, ctl2_d;

    logic [1:0]    speed_norm_s;
    logic [CW:0]   p_q_s, p_d_s;
    logic          last_s, load_hi_s;
    logic [CW+1:0] h1_s, h2_s;

    assign speed_norm_s = speed_i[1] ? 2'b10 : speed_i;
    assign p_q_s        = period_of(active_q);
    assign last_s       = ({1'b0, cnt_q} == (p_q_s - (CW+1)'(1)));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= speed_norm_s;
            cnt_q    <= {CW{1'b0}};
            phase_q  <= PH_A;
            hi_q     <= 4'h0;
            en_q     <= 1'b0;
            er_q     <= 1'b0;
            clk_en_q <= 1'b0;
            chg_q    <= 1'b0;
            txc1_q   <= 1'b1;
            txc2_q   <= 1'b0;
            txd1_q   <= 4'h0;
            txd2_q   <= 4'h0;
            ctl1_q   <= 1'b0;
            ctl2_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            en_q     <= en_d;
            er_q     <= er_d;
            clk_en_q <= clk_en_d;
            chg_q    <= chg_d;
            txc1_q   <= txc1_d;
            txc2_q   <= txc2_d;
            txd1_q   <= txd1_d;
            txd2_q   <= txd2_d;
            ctl1_q   <= ctl1_d;
            ctl2_q   <= ctl2_d;
        end
    end

    // Period counter, nibble phase, byte capture and speed switching
    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        en_d      = en_q;
        er_d      = er_q;
        chg_d     = 1'b0;
        load_hi_s = 1'b0;
        if (clk_en_q) begin
            // Byte boundary: the registered enable marks the cycle the MAC byte is taken
            hi_d    = gmii_txd_i[7:4];
            en_d    = gmii_tx_en_i;
            er_d    = gmii_tx_er_i;
            cnt_d   = {CW{1'b0}};
            phase_d = PH_A;
            if (speed_norm_s != active_q) begin
                active_d = speed_norm_s;
                chg_d    = 1'b1;
            end else begin
                active_d = active_q;
                chg_d    = 1'b0;
            end
        end else if (active_q[1]) begin
            cnt_d   = {CW{1'b0}};
            phase_d = PH_A;
        end else if (last_s) begin
            cnt_d     = {CW{1'b0}};
            phase_d   = BYTE_SPLIT ? PH_B : PH_A;
            load_hi_s = BYTE_SPLIT;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Next-cycle output values derived from the next counter state
    always_comb begin
        p_d_s  = period_of(active_d);
        h1_s   = {1'b0, cnt_d, 1'b0};
        h2_s   = {1'b0, cnt_d, 1'b1};
        txd1_d = txd1_q;
        txd2_d = txd2_q;
        ctl1_d = ctl1_q;
        ctl2_d = ctl2_q;
        if (active_d[1]) begin
            txc1_d   = 1'b1;
            txc2_d   = 1'b0;
            clk_en_d = 1'b1;
            if (clk_en_q) begin
                txd1_d = gmii_txd_i[3:0];
                txd2_d = gmii_txd_i[7:4];
                ctl1_d = gmii_tx_en_i;
                ctl2_d = gmii_tx_en_i ^ gmii_tx_er_i;
            end else begin
                txd1_d = txd1_q;
                txd2_d = txd2_q;
            end
        end else begin
            // Half-cycle index below P is the low half of TXC, giving 50% duty for odd P too
            txc1_d   = (h1_s >= {1'b0, p_d_s});
            txc2_d   = (h2_s >= {1'b0, p_d_s});
            clk_en_d = ({1'b0, cnt_d} == (p_d_s - (CW+1)'(1))) &&
                       ((phase_d == PH_B) || !BYTE_SPLIT);
            if (clk_en_q) begin
                txd1_d = gmii_txd_i[3:0];
                txd2_d = gmii_txd_i[3:0];
            end else if (load_hi_s) begin
                txd1_d = hi_q;
                txd2_d = hi_q;
            end else begin
                txd1_d = txd1_q;
                txd2_d = txd2_q;
            end
            ctl1_d = txc1_d ? (en_d ^ er_d) : en_d;
            ctl2_d = txc2_d ? (en_d ^ er_d) : en_d;
        end
    end

    assign gmii_tx_clk_en_o = clk_en_q;
    assign txc_d1_o         = txc1_q;
    assign txc_d2_o         = txc2_q;
    assign txd_d1_o         = txd1_q;
    assign txd_d2_o         = txd2_q;
    assign tx_ctl_d1_o      = ctl1_q;
    assign tx_ctl_d2_o      = ctl2_q;
    assign active_speed_o   = active_q;
    assign speed_change_o   = chg_q;

endmodule

// File: tb/tb_rgmii_tx_speed_gen.sv
// Directed bench for rgmii_tx_speed_gen: a 1G vector table plus hand-written 10/100 sequences.
module tb_rgmii_tx_speed_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] txd;
    logic       en, er;

    logic       ce, t1, t2, c1, c2, chg;
    logic [3:0] d1, d2;
    logic [1:0] act;

    logic       ns_ce, ns_t1, ns_t2, ns_c1, ns_c2, ns_chg;
    logic [3:0] ns_d1, ns_d2;
    logic [1:0] ns_act;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rgmii_tx_speed_gen #(.DIV_100M(5), .DIV_10M(50), .BYTE_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .speed_i(speed), .gmii_txd_i(txd),
        .gmii_tx_en_i(en), .gmii_tx_er_i(er), .gmii_tx_clk_en_o(ce),
        .txc_d1_o(t1), .txc_d2_o(t2), .txd_d1_o(d1), .txd_d2_o(d2),
        .tx_ctl_d1_o(c1), .tx_ctl_d2_o(c2), .active_speed_o(act),
        .speed_change_o(chg)
    );

    rgmii_tx_speed_gen #(.DIV_100M(5), .DIV_10M(50), .BYTE_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .speed_i(speed), .gmii_txd_i(txd),
        .gmii_tx_en_i(en), .gmii_tx_er_i(er), .gmii_tx_clk_en_o(ns_ce),
        .txc_d1_o(ns_t1), .txc_d2_o(ns_t2), .txd_d1_o(ns_d1), .txd_d2_o(ns_d2),
        .tx_ctl_d1_o(ns_c1), .tx_ctl_d2_o(ns_c2), .active_speed_o(ns_act),
        .speed_change_o(ns_chg)
    );

    logic [15:0] obs;
    assign obs = {ce, t1, t2, d1, d2, c1, c2, act, chg};

    typedef struct {
        logic        rst;
        logic [1:0]  speed;
        logic [7:0]  txd;
        logic        en;
        logic        er;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] mk(input logic xce, input logic xt1, input logic xt2,
                                       input logic [3:0] xd1, input logic [3:0] xd2,
                                       input logic xc1, input logic xc2,
                                       input logic [1:0] xact, input logic xchg);
        return {xce, xt1, xt2, xd1, xd2, xc1, xc2, xact, xchg};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic do_reset(input logic [1:0] spd, input logic [1:0] norm);
        rst   = 1'b1;
        speed = spd;
        step();
        cmp("reset", obs, mk(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, norm, 1'b0));
        rst = 1'b0;
    endtask

    // Runs cycles 1..n after a reset with constant inputs; first byte is taken at cycle 2p-1.
    task automatic check_seq(input string name, input int n, input int p, input logic [7:0] b,
                             input logic xen, input logic xer, input logic [1:0] xact);
        int         cnt, ph;
        logic       et1, et2, ece, ec1, ec2;
        logic [3:0] ed;
        for (int c = 1; c <= n; c++) begin
            step();
            cnt = c % p;
            ph  = (c / p) % 2;
            et1 = (2 * cnt >= p);
            et2 = (2 * cnt + 1 >= p);
            ece = (cnt == p - 1) && (ph == 1);
            if (c < 2 * p) begin
                ed  = 4'h0;
                ec1 = 1'b0;
                ec2 = 1'b0;
            end else begin
                ed  = (ph == 1) ? b[7:4] : b[3:0];
                ec1 = et1 ? (xen ^ xer) : xen;
                ec2 = et2 ? (xen ^ xer) : xen;
            end
            cmp($sformatf("%s_c%0d", name, c), obs, mk(ece, et1, et2, ed, ed, ec1, ec2, xact, 1'b0));
        end
    endtask

    initial begin
        int   chg_cnt;
        logic early;
        rst   = 1'b1;
        speed = 2'b11;
        txd   = 8'h00;
        en    = 1'b0;
        er    = 1'b0;

        // 1G table: reset with 2'b11, byte path, then a switch to 100M at a boundary
        vecs[0] = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0)};
        vecs[1] = '{1'b0, 2'b10, 8'hA5, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0)};
        vecs[2] = '{1'b0, 2'b10, 8'hA5, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1, 1'b1, 2'b10, 1'b0)};
        vecs[3] = '{1'b0, 2'b11, 8'h3C, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 4'hC, 4'h3, 1'b1, 1'b1, 2'b10, 1'b0)};
        vecs[4] = '{1'b0, 2'b10, 8'h3C, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 4'hC, 4'h3, 1'b1, 1'b0, 2'b10, 1'b0)};
        vecs[5] = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b0)};
        vecs[6] = '{1'b0, 2'b01, 8'h5A, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b1, 1'b1, 2'b01, 1'b1)};
        vecs[7] = '{1'b0, 2'b01, 8'h5A, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b1, 1'b1, 2'b01, 1'b0)};

        for (int i = 0; i < 8; i++) begin
            rst   = vecs[i].rst;
            speed = vecs[i].speed;
            txd   = vecs[i].txd;
            en    = vecs[i].en;
            er    = vecs[i].er;
            step();
            cmp($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // 100M with nibble split
        do_reset(2'b01, 2'b01);
        txd = 8'hA5; en = 1'b1; er = 1'b0;
        check_seq("m100", 30, 5, 8'hA5, 1'b1, 1'b0, 2'b01);

        // 10M with en=er=1: TX_CTL low on the high TXC halves
        do_reset(2'b00, 2'b00);
        txd = 8'h96; en = 1'b1; er = 1'b1;
        check_seq("m10er", 200, 50, 8'h96, 1'b1, 1'b1, 2'b00);

        // 100M -> 10M requested mid-byte
        do_reset(2'b01, 2'b01);
        txd = 8'hA5; en = 1'b1; er = 1'b0;
        step();
        step();
        speed   = 2'b00;
        chg_cnt = 0;
        early   = 1'b0;
        for (int c = 3; c <= 120; c++) begin
            step();
            if (chg) chg_cnt++;
            if (c == 9)  cmp("chg_hold", {13'd0, act, ce}, {13'd0, 2'b01, 1'b1});
            if (c == 10) cmp("chg_apply", {13'd0, act, chg}, {13'd0, 2'b00, 1'b1});
            if (c == 34) cmp("chg_txc_low", {15'd0, t1}, 16'd0);
            if (c == 35) cmp("chg_txc_high", {15'd0, t1}, 16'd1);
            if (c > 10 && c < 109 && ce) early = 1'b1;
            if (c == 109) cmp("chg_next_byte", {15'd0, ce}, 16'd1);
        end
        cmp("chg_pulses", 16'(chg_cnt), 16'd1);
        cmp("chg_no_early_en", {15'd0, early}, 16'd0);

        // Request withdrawn before the boundary is ignored
        do_reset(2'b01, 2'b01);
        step();
        step();
        speed   = 2'b00;
        chg_cnt = 0;
        for (int c = 3; c <= 30; c++) begin
            step();
            if (c == 5) speed = 2'b01;
            if (chg) chg_cnt++;
        end
        cmp("revert_pulses", 16'(chg_cnt), 16'd0);
        cmp("revert_speed", {14'd0, act}, {14'd0, 2'b01});

        // Nibble-per-period variant
        do_reset(2'b01, 2'b01);
        txd = 8'h37; en = 1'b1; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            logic       ece;
            logic [3:0] ed;
            step();
            ece = ((c % 5) == 4);
            ed  = (c >= 5) ? 4'h7 : 4'h0;
            cmp($sformatf("nosplit_c%0d", c), {7'd0, ns_ce, ns_d1, ns_d2}, {7'd0, ece, ed, ed});
        end

        // Reset in the middle of a 10M frame
        do_reset(2'b00, 2'b00);
        txd = 8'h96; en = 1'b1; er = 1'b0;
        check_seq("m10a", 150, 50, 8'h96, 1'b1, 1'b0, 2'b00);
        do_reset(2'b00, 2'b00);
        check_seq("m10b", 110, 50, 8'h96, 1'b1, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
